// File: rtl/shift_pkg.sv
// Shared definitions for the shift/rotate sequencer: op codes, FSM states,
// per-cycle step limit and the illegal-op check.
package shift_pkg;

  localparam logic [2:0] OP_ROR = 3'b000;
  localparam logic [2:0] OP_ROL = 3'b001;
  localparam logic [2:0] OP_LSR = 3'b010;
  localparam logic [2:0] OP_LSL = 3'b011;
  localparam logic [2:0] OP_ASR = 3'b100;

  // Largest amount one step can apply: what a 4-bit step select encodes.
  localparam int MAX_STEP = 15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic op_illegal(input logic [2:0] op);
    return op > OP_ASR;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: applies one op by 0..2^SW-1 bits.
// Grown from the original 4-bit rotate-right element to cover all five ops.
module shift_step
  import shift_pkg::*;
#(
  parameter int DW = 32,
  parameter int SW = 4
) (
  input  logic [DW-1:0] i_data,
  input  logic [SW-1:0] i_step,
  input  logic [2:0]    i_op,
  output logic [DW-1:0] o_data
);

  always_comb begin
    // NOTE: give every combinational output a default first so no path through
    // the case leaves it unassigned and infers a latch.
    o_data = i_data;
    case (i_op)
      OP_ROR:  o_data = (i_data >> i_step) | (i_data << (DW - int'(i_step)));
      OP_ROL:  o_data = (i_data << i_step) | (i_data >> (DW - int'(i_step)));
      OP_LSR:  o_data = i_data >> i_step;
      OP_LSL:  o_data = i_data << i_step;
      OP_ASR:  o_data = DW'($signed(i_data) >>> i_step);
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift/rotate sequencer: breaks a shift of up to 31 bits into
// steps of at most MAX_STEP and returns the result over a valid/ready handshake.
module shift_seq
  import shift_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int SW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [DW-1:0] i_data,
  input  logic [AW-1:0] i_amt,
  input  logic [2:0]    i_op,
  input  logic          i_ready,
  output logic          o_ready,
  output logic          o_busy,
  output logic          o_valid,
  output logic [DW-1:0] o_result,
  output logic          o_err
);

  state_e        r_state;
  logic [DW-1:0] r_acc;
  logic [AW-1:0] r_rem;
  logic [2:0]    r_op;
  logic          r_ready;
  logic          r_busy;
  logic          r_valid;
  logic [DW-1:0] r_result;
  logic          r_err;

  logic [SW-1:0] w_step;
  logic [DW-1:0] w_next;
  logic          w_last;

  assign w_step = (r_rem > AW'(MAX_STEP)) ? SW'(MAX_STEP) : r_rem[SW-1:0];
  assign w_last = (r_rem == AW'(w_step));

  shift_step #(
    .DW(DW),
    .SW(SW)
  ) u_step (
    .i_data(r_acc),
    .i_step(w_step),
    .i_op  (r_op),
    .o_data(w_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_rem    <= '0;
      r_op     <= OP_ROR;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_acc   <= i_data;
            r_rem   <= i_amt;
            r_op    <= i_op;
            r_ready <= 1'b0;
            if (i_amt == '0 || op_illegal(i_op)) begin
              r_state  <= S_DONE;
              r_valid  <= 1'b1;
              r_result <= i_data;
              r_err    <= op_illegal(i_op);
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_acc <= w_next;
          r_rem <= r_rem - AW'(w_step);
          if (w_last) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_valid  <= 1'b1;
            r_result <= w_next;
            r_err    <= 1'b0;
          end
        end
        S_DONE: begin
          // A start seen alongside i_ready is dropped: o_ready is still low here.
          if (i_ready) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready  = r_ready;
  assign o_busy   = r_busy;
  assign o_valid  = r_valid;
  assign o_result = r_result;
  assign o_err    = r_err;

endmodule

// File: tb/tb_shift_seq.sv
// Directed testbench for shift_seq: latency, results, hold, ignored starts,
// mid-run reset and the illegal-op path, against hand-computed values.
module tb_shift_seq;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TIMEOUT = 40;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic [DW-1:0] i_data;
  logic [AW-1:0] i_amt;
  logic [2:0]    i_op;
  logic          i_ready;
  logic          o_ready;
  logic          o_busy;
  logic          o_valid;
  logic [DW-1:0] o_result;
  logic          o_err;

  int checks   = 0;
  int failures = 0;

  shift_seq dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_data  (i_data),
    .i_amt   (i_amt),
    .i_op    (i_op),
    .i_ready (i_ready),
    .o_ready (o_ready),
    .o_busy  (o_busy),
    .o_valid (o_valid),
    .o_result(o_result),
    .o_err   (o_err)
  );

  always #5 i_clk = ~i_clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step_clk();
    @(posedge i_clk);
    #1;
  endtask

  // Present a request in the current cycle (cycle 0) and clock it in.
  task automatic issue(input logic [2:0] op, input logic [DW-1:0] data, input logic [AW-1:0] amt);
    i_op    = op;
    i_data  = data;
    i_amt   = amt;
    i_start = 1'b1;
    step_clk();
    i_start = 1'b0;
  endtask

  // Called in cycle 1; returns the cycle number in which o_valid is first seen.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!o_valid && cyc < TIMEOUT) begin
      step_clk();
      cyc++;
    end
    if (!o_valid) cyc = -1;
  endtask

  task automatic release_result();
    i_ready = 1'b1;
    step_clk();
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    step_clk();
    step_clk();
    i_rst = 1'b0;
    checks++;
    if ({o_ready, o_busy, o_valid, o_err} !== 4'b1000 || o_result !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: rdy/busy/vld/err=%b result=%h, expected 1000 result=00000000",
               {o_ready, o_busy, o_valid, o_err}, o_result);
    end
  endtask

  task automatic test_ror_single();
    int cyc;
    issue(3'b000, 32'h0000_0001, 5'd1);
    checks++;
    if (o_busy !== 1'b1 || o_ready !== 1'b0) begin
      failures++;
      $display("FAIL ror1_run_flags: busy=%b ready=%b, expected busy=1 ready=0", o_busy, o_ready);
    end
    wait_valid(cyc);
    checks++;
    if (cyc !== 2) begin
      failures++;
      $display("FAIL ror1_latency: valid in cycle %0d, expected 2", cyc);
    end
    checks++;
    if (o_result !== 32'h8000_0000 || o_err !== 1'b0) begin
      failures++;
      $display("FAIL ror1_result: result=%h err=%b, expected 80000000 err=0", o_result, o_err);
    end
    release_result();
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      failures++;
      $display("FAIL ror1_release: valid=%b ready=%b, expected valid=0 ready=1", o_valid, o_ready);
    end
  endtask

  task automatic test_rol_31();
    int cyc;
    issue(3'b001, 32'h8000_0001, 5'd31);
    wait_valid(cyc);
    checks++;
    if (cyc !== 4) begin
      failures++;
      $display("FAIL rol31_latency: valid in cycle %0d, expected 4", cyc);
    end
    checks++;
    if (o_result !== 32'hC000_0000) begin
      failures++;
      $display("FAIL rol31_result: result=%h, expected c0000000", o_result);
    end
    release_result();
  endtask

  task automatic test_shifts_20();
    int cyc;
    issue(3'b100, 32'h8000_0000, 5'd20);
    wait_valid(cyc);
    checks++;
    if (cyc !== 3) begin
      failures++;
      $display("FAIL asr20_latency: valid in cycle %0d, expected 3", cyc);
    end
    checks++;
    if (o_result !== 32'hFFFF_F800) begin
      failures++;
      $display("FAIL asr20_result: result=%h, expected fffff800", o_result);
    end
    release_result();

    issue(3'b010, 32'h8000_0000, 5'd20);
    wait_valid(cyc);
    checks++;
    if (cyc !== 3 || o_result !== 32'h0000_0800) begin
      failures++;
      $display("FAIL lsr20_result: cycle=%0d result=%h, expected cycle 3 result 00000800", cyc, o_result);
    end
    release_result();

    issue(3'b011, 32'h0000_0001, 5'd16);
    wait_valid(cyc);
    checks++;
    if (cyc !== 3 || o_result !== 32'h0001_0000) begin
      failures++;
      $display("FAIL lsl16_result: cycle=%0d result=%h, expected cycle 3 result 00010000", cyc, o_result);
    end
    release_result();

    issue(3'b100, 32'h7000_0000, 5'd31);
    wait_valid(cyc);
    checks++;
    if (cyc !== 4 || o_result !== 32'h0000_0000) begin
      failures++;
      $display("FAIL asr31_pos_result: cycle=%0d result=%h, expected cycle 4 result 00000000", cyc, o_result);
    end
    release_result();
  endtask

  task automatic test_hold_and_ignore();
    int cyc;
    issue(3'b011, 32'h1234_5678, 5'd0);
    wait_valid(cyc);
    checks++;
    if (cyc !== 1 || o_result !== 32'h1234_5678) begin
      failures++;
      $display("FAIL amt0_result: cycle=%0d result=%h, expected cycle 1 result 12345678", cyc, o_result);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        i_op = 3'b000; i_data = 32'hAAAA_5555; i_amt = 5'd3; i_start = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      step_clk();
      checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_busy !== 1'b0 || o_result !== 32'h1234_5678) begin
        failures++;
        $display("FAIL hold_cycle%0d: valid=%b ready=%b busy=%b result=%h, expected 1 0 0 12345678",
                 i, o_valid, o_ready, o_busy, o_result);
      end
    end
    // Start alongside the accepting i_ready must be dropped.
    i_start = 1'b1;
    i_ready = 1'b1;
    step_clk();
    i_start = 1'b0;
    i_ready = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_ignore: valid=%b ready=%b busy=%b, expected 0 1 0", o_valid, o_ready, o_busy);
    end
    step_clk();
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_result !== 32'h1234_5678) begin
      failures++;
      $display("FAIL idle_after_ignore: valid=%b busy=%b result=%h, expected 0 0 12345678", o_valid, o_busy, o_result);
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    issue(3'b000, 32'h1357_9BDF, 5'd31);
    step_clk();
    i_rst = 1'b1;
    step_clk();
    i_rst = 1'b0;
    checks++;
    if ({o_ready, o_busy, o_valid, o_err} !== 4'b1000 || o_result !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset: rdy/busy/vld/err=%b result=%h, expected 1000 result=00000000",
               {o_ready, o_busy, o_valid, o_err}, o_result);
    end
    issue(3'b000, 32'h0000_000F, 5'd4);
    wait_valid(cyc);
    checks++;
    if (cyc !== 2 || o_result !== 32'hF000_0000) begin
      failures++;
      $display("FAIL after_reset_ror4: cycle=%0d result=%h, expected cycle 2 result f0000000", cyc, o_result);
    end
    release_result();
  endtask

  task automatic test_illegal_op();
    int cyc;
    issue(3'b111, 32'hDEAD_BEEF, 5'd7);
    wait_valid(cyc);
    checks++;
    if (cyc !== 1 || o_err !== 1'b1 || o_result !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL illegal_op: cycle=%0d err=%b result=%h, expected cycle 1 err 1 result deadbeef",
               cyc, o_err, o_result);
    end
    release_result();
    issue(3'b001, 32'h0000_0003, 5'd2);
    wait_valid(cyc);
    checks++;
    if (o_err !== 1'b0 || o_result !== 32'h0000_000C) begin
      failures++;
      $display("FAIL err_clears: err=%b result=%h, expected err 0 result 0000000c", o_err, o_result);
    end
    release_result();
  endtask

  initial begin
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_data  = '0;
    i_amt   = '0;
    i_op    = 3'b000;
    i_ready = 1'b0;
    #1;
    test_reset();
    test_ror_single();
    test_rol_31();
    test_shifts_20();
    test_hold_and_ignore();
    test_mid_reset();
    test_illegal_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Multi-cycle shift/rotate sequencer for the CPU datapath execute stage.
- Accepts a 32-bit operand, a 5-bit amount and an operation code.
- Builds the full shift from repeated single-cycle steps of at most 15 bits, the range a 4-bit step select can encode.
- Returns the result through a valid/ready handshake; the ALU issue logic stalls on it.

Parameters:
- DW, 32, data width.
- AW, 5, amount width (log2 DW).
- SW, 4, step-select width; maximum step per cycle is 2^SW-1 = 15.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_start  input  1  request; accepted only when o_ready=1.
- i_data  input  DW  operand.
- i_amt  input  AW  shift amount, 0..31.
- i_op  input  3  operation: 000 ROR, 001 ROL, 010 LSR, 011 LSL, 100 ASR; 101..111 illegal.
- i_ready  input  1  consumer accepts result.
- o_ready  output  1  block idle, can accept i_start.
- o_busy  output  1  stepping in progress.
- o_valid  output  1  result available.
- o_result  output  DW  result.
- o_err  output  1  illegal op flag, qualified by o_valid.

Behaviour:
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Output reset values: o_ready=1, o_busy=0, o_valid=0, o_result=0, o_err=0.
- IDLE:
  - o_ready=1.
  - On i_start, latch i_data, i_amt and i_op into working registers (acc, rem, op).
  - If i_amt==0 or the op is illegal, go straight to DONE: result = latched data, o_err = (op illegal).
  - Otherwise go to RUN.
- RUN:
  - o_busy=1 and o_ready=0.
  - Each cycle: step = min(rem, 15); acc = op(acc, step); rem = rem - step.
  - When rem reaches 0 the next state is DONE, with o_result = updated acc.
- Step semantics per op:
  - ROR/ROL: circular rotation.
  - LSR/LSL: zero fill.
  - ASR: fills with acc[DW-1] sampled at the start of that step.
  - The composition of steps equals the single-shot shift by the full amount.
- Latency: i_start sampled in cycle 0; RUN occupies cycles 1..k with k = ceil(amt/15); o_valid rises in cycle k+1. For amt=0 or an illegal op, o_valid rises in cycle 1.
- DONE:
  - o_valid=1; o_result and o_err are held stable until i_ready=1.
  - On i_ready, return to IDLE; o_valid drops the next cycle.
- Ignored requests:
  - i_start while not IDLE is ignored and not queued.
  - i_start in the same cycle as DONE+i_ready is ignored; o_ready is still 0 that cycle.
- Reset mid-operation: any state goes to IDLE the next cycle, all outputs return to reset values, and the in-flight request is dropped.
- Amount is unsigned. Rotations use the amount directly (no modulo needed, max 31 < DW). Shifts by 31 leave only the fill bits plus bit 0 or bit 31.
- o_result changes only on entry to DONE; it is held from DONE until the next DONE.

Decomposition:
- Shared package shift_pkg:
  - Op-code localparams (OP_ROR..OP_ASR).
  - State encoding (S_IDLE, S_RUN, S_DONE).
  - MAX_STEP = 15.
  - Helper function for the illegal-op check.
- Sub-module shift_step: combinational single-step unit.
  - Inputs: DW data, SW-bit step, op.
  - Output: shifted data.
  - Extends the existing 4-bit rotate-right datapath element to all five ops.
- shift_seq holds the FSM, the rem counter and the acc register.

Test Plan:
- ROR, data 0x0000_0001, amt 1 -> 1 RUN cycle; o_valid in cycle 2; o_result 0x8000_0000; o_err 0.
- ROL, data 0x8000_0001, amt 31 -> RUN steps 15,15,1; o_valid in cycle 4; o_result 0xC000_0000.
- ASR, data 0x8000_0000, amt 20 -> RUN steps 15,5; o_valid in cycle 3; o_result 0xFFFF_F800. LSR with the same data and amt -> 0x0000_0800.
- LSL, data 0x1234_5678, amt 0 -> o_valid in cycle 1; o_result 0x1234_5678. Hold i_ready=0 for 5 cycles: result stable, o_ready=0. i_start pulsed during the hold is ignored. i_ready=1 -> IDLE next cycle.
- Assert i_rst in the 2nd RUN cycle of an amt=31 request -> next cycle o_ready=1, o_busy=0, o_valid=0, o_result=0. A fresh ROR of 0xF by 4 then yields 0xF000_0000.
- op=3'b111, data 0xDEAD_BEEF, amt 7 -> o_valid in cycle 1; o_err=1; o_result 0xDEAD_BEEF.
